spi_cmd_parser: RTL and testbench
=================================

SPI_CMD_PARSER -- requirements
Module: spi_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the number of idle clk cycles inside a partial frame before abort (used only with SPI_CMD_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port spi_nss  input  1  SPI chip select, active low, already synchronised to clk.
REQ-005 SHALL have port rx_valid  input  1  Avalon-ST valid from the SPI slave byte source.
REQ-006 SHALL have port rx_data  input  8  received MOSI byte.
REQ-007 SHALL have port rx_ready  output  1  Avalon-ST ready to the SPI slave.
REQ-008 SHALL have ports freq and freq2  output  16  voice 1/2 phase increments.
REQ-009 SHALL have ports env and env2  output  8  voice 1/2 envelope levels.
REQ-010 SHALL have ports freq_stb, freq2_stb, env_stb, env2_stb  output  1  one-cycle update pulses.
REQ-011 SHALL have port cmd_err  output  1  one-cycle pulse on unknown command or aborted frame.
REQ-012 SHALL have port frame_cnt  output  8  count of committed frames, wraps 255->0.

Function
REQ-013 SHALL accept a byte on any rising edge where rx_valid and rx_ready are both 1.
REQ-014 SHALL drive rx_ready 1 at all times outside reset; a byte is never stalled.
REQ-015 SHALL implement FSM states IDLE, ARG_HI, ARG_LO.
REQ-016 In IDLE, accepted byte 0x01 or 0x03 -> ARG_HI; byte 0x02 or 0x04 -> ARG_LO; the command is latched.
REQ-017 In IDLE, any other accepted byte SHALL be discarded, the FSM SHALL stay in IDLE, and cmd_err SHALL pulse.
REQ-018 In ARG_HI, the accepted byte SHALL be held as the high byte -> ARG_LO.
REQ-019 In ARG_LO, the accepted byte completes the frame -> IDLE, with commit on the same edge.
- 0x01: freq = {hi, byte}
- 0x03: freq2 = {hi, byte}
- 0x02: env = byte
- 0x04: env2 = byte
REQ-020 On commit, the matching *_stb SHALL be 1 for exactly the following cycle.
REQ-021 On commit, frame_cnt SHALL increment on the same edge.
REQ-022 Outputs freq, freq2, env and env2 SHALL change only on commit; partial frames never alter them.
REQ-023 When spi_nss=1 in ARG_HI or ARG_LO with no byte accepted that cycle, the FSM SHALL abort -> IDLE, discard the partial data, and pulse cmd_err.
REQ-024 When spi_nss=1 and the final byte is accepted on the same edge, the frame SHALL commit with no abort.
REQ-025 When spi_nss=1 and a non-final byte is accepted on the same edge, the FSM SHALL abort and the byte SHALL be discarded.
REQ-026 spi_nss=1 in IDLE SHALL have no effect.
REQ-027 Back-to-back frames with rx_valid on consecutive cycles SHALL be parsed with no lost byte.

Reset
REQ-028 nreset=0 SHALL asynchronously force the following state: FSM IDLE; freq, freq2, env and env2 = 0; all strobes = 0; cmd_err = 0; frame_cnt = 0; rx_ready = 0; timeout counter = 0.
REQ-029 After nreset deasserts, rx_ready SHALL be 1 from the first clk edge onward.
REQ-030 Reset mid-frame SHALL discard the partial frame without pulsing cmd_err.

Configuration
REQ-031 With macro SPI_CMD_TIMEOUT_EN defined, a counter SHALL count cycles in ARG_HI/ARG_LO without an accepted byte.
- The counter clears on every accepted byte.
- On reaching TIMEOUT_CYCLES, the FSM SHALL abort -> IDLE and pulse cmd_err.
REQ-032 Without SPI_CMD_TIMEOUT_EN, no timeout logic SHALL exist, and a partial frame SHALL wait indefinitely for data or spi_nss.

Verification
REQ-033 Bytes 0x01,0x12,0x34 -> freq=0x1234, freq_stb 1 cycle, frame_cnt=1, other outputs unchanged.
REQ-034 Bytes 0x04,0xA5 then 0x03,0xBE,0xEF on consecutive cycles -> env2=0xA5 then freq2=0xBEEF, two strobes, frame_cnt=2.
REQ-035 Byte 0x07 -> cmd_err pulse, state stays IDLE; then 0x02,0x40 -> env=0x40.
REQ-036 Bytes 0x01,0x55, then spi_nss=1 with no byte -> cmd_err pulse, freq remains 0; then 0x01,0x00,0x10 -> freq=0x0010.
REQ-037 With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=8: bytes 0x03,0x11, then idle 8 cycles -> cmd_err pulse and IDLE; without the macro, the same stimulus plus 0x22 after 20 cycles -> freq2=0x1122.
REQ-038 Assert nreset low after 0x01,0xFF -> all outputs 0 immediately; 256 committed frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/spi_cmd_parser_if.sv
// Byte stream from the SPI slave front end into the command parser:
// chip select plus an Avalon-ST style valid/ready byte channel.
interface spi_cmd_parser_if;
    // A byte transfers on a rising clk edge where rx_valid and rx_ready are both 1;
    // rx_data is only meaningful while rx_valid is 1, and the parser never stalls.
    logic       spi_nss;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output spi_nss, output rx_valid, output rx_data, input rx_ready);
    modport slave  (input spi_nss, input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/spi_cmd_parser.sv
// Parses 2- and 3-byte SPI command frames into voice frequency/envelope registers.
// Optional partial-frame timeout is built only when SPI_CMD_TIMEOUT_EN is defined.
module spi_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              nreset,
    spi_cmd_parser_if.slave   rx,
    output logic [15:0]       freq,
    output logic [15:0]       freq2,
    output logic [7:0]        env,
    output logic [7:0]        env2,
    output logic              freq_stb,
    output logic              freq2_stb,
    output logic              env_stb,
    output logic              env2_stb,
    output logic              cmd_err,
    output logic [7:0]        frame_cnt,
    output logic [1:0]        state_dbg
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARG_HI = 2'd1,
        ARG_LO = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cmd;
    logic [7:0] hi;
    logic       ready_q;
    logic       accept;
    logic       in_arg;
    logic       idle_abort;

    assign rx.rx_ready = ready_q;
    assign accept      = rx.rx_valid && ready_q;
    assign in_arg      = (state == ARG_HI) || (state == ARG_LO);
    assign state_dbg   = state;

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // Hit on the cycle that would make TIMEOUT_CYCLES idle cycles in a row.
    assign to_hit     = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign idle_abort = in_arg && !accept && (rx.spi_nss || to_hit);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            to_cnt <= '0;
        end else if (!in_arg || accept || idle_abort) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign idle_abort = in_arg && !accept && rx.spi_nss;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cmd       <= '0;
            hi        <= '0;
            ready_q   <= 1'b0;
            freq      <= '0;
            freq2     <= '0;
            env       <= '0;
            env2      <= '0;
            freq_stb  <= 1'b0;
            freq2_stb <= 1'b0;
            env_stb   <= 1'b0;
            env2_stb  <= 1'b0;
            cmd_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            ready_q   <= 1'b1;
            freq_stb  <= 1'b0;
            freq2_stb <= 1'b0;
            env_stb   <= 1'b0;
            env2_stb  <= 1'b0;
            cmd_err   <= 1'b0;

            if (idle_abort) begin
                state   <= IDLE;
                cmd_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            case (rx.rx_data)
                                8'h01, 8'h03: begin
                                    state <= ARG_HI;
                                    cmd   <= rx.rx_data[2:0];
                                end
                                8'h02, 8'h04: begin
                                    state <= ARG_LO;
                                    cmd   <= rx.rx_data[2:0];
                                end
                                default: cmd_err <= 1'b1;
                            endcase
                        end
                    end
                    ARG_HI: begin
                        // Deselect on a non-final byte kills the frame and drops the byte.
                        if (accept) begin
                            if (rx.spi_nss) begin
                                state   <= IDLE;
                                cmd_err <= 1'b1;
                            end else begin
                                hi    <= rx.rx_data;
                                state <= ARG_LO;
                            end
                        end
                    end
                    ARG_LO: begin
                        if (accept) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 8'd1;
                            case (cmd)
                                3'd1: begin
                                    freq     <= {hi, rx.rx_data};
                                    freq_stb <= 1'b1;
                                end
                                3'd3: begin
                                    freq2     <= {hi, rx.rx_data};
                                    freq2_stb <= 1'b1;
                                end
                                3'd2: begin
                                    env     <= rx.rx_data;
                                    env_stb <= 1'b1;
                                end
                                3'd4: begin
                                    env2     <= rx.rx_data;
                                    env2_stb <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser; timeout expectations follow SPI_CMD_TIMEOUT_EN.
module tb_spi_cmd_parser;

    logic        clk;
    logic        nreset;
    logic [15:0] freq, freq2;
    logic [7:0]  env, env2, frame_cnt;
    logic        freq_stb, freq2_stb, env_stb, env2_stb, cmd_err;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    spi_cmd_parser_if bus ();

    spi_cmd_parser #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .rx        (bus),
        .freq      (freq),
        .freq2     (freq2),
        .env       (env),
        .env2      (env2),
        .freq_stb  (freq_stb),
        .freq2_stb (freq2_stb),
        .env_stb   (env_stb),
        .env2_stb  (env2_stb),
        .cmd_err   (cmd_err),
        .frame_cnt (frame_cnt),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; presents a byte across the next rising edge.
    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        nreset       = 1'b0;
        bus.spi_nss  = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.rx_ready, 0);
        check("rst_freq", freq, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_state", state_dbg, 0);
        nreset = 1'b1;
        @(negedge clk);
        check("ready_after_rst", bus.rx_ready, 1);

        // 0x01 0x12 0x34 -> freq
        send(8'h01);
        send(8'h12);
        check("partial_freq", freq, 0);
        check("partial_state", state_dbg, 2);
        send(8'h34);
        check("freq", freq, 16'h1234);
        check("freq_stb_hi", freq_stb, 1);
        check("frame_cnt_1", frame_cnt, 1);
        check("freq2_untouched", freq2, 0);
        check("env_untouched", env, 0);
        idle(1);
        check("freq_stb_lo", freq_stb, 0);

        // Back-to-back env2 then freq2
        send(8'h04);
        send(8'hA5);
        check("env2", env2, 8'hA5);
        check("env2_stb_hi", env2_stb, 1);
        send(8'h03);
        check("env2_stb_lo", env2_stb, 0);
        send(8'hBE);
        send(8'hEF);
        check("freq2", freq2, 16'hBEEF);
        check("freq2_stb_hi", freq2_stb, 1);
        check("frame_cnt_3", frame_cnt, 3);
        idle(1);

        // Unknown command
        send(8'h07);
        check("bad_cmd_err", cmd_err, 1);
        check("bad_cmd_state", state_dbg, 0);
        send(8'h02);
        check("cmd_err_clear", cmd_err, 0);
        send(8'h40);
        check("env", env, 8'h40);
        check("frame_cnt_4", frame_cnt, 4);
        idle(1);

        // Deselect mid-frame with no byte
        send(8'h01);
        send(8'h55);
        bus.rx_valid = 1'b0;
        bus.spi_nss  = 1'b1;
        @(negedge clk);
        check("nss_abort_err", cmd_err, 1);
        check("nss_abort_state", state_dbg, 0);
        check("nss_abort_freq", freq, 16'h1234);
        bus.spi_nss = 1'b0;
        send(8'h01);
        send(8'h00);
        send(8'h10);
        check("freq_after_abort", freq, 16'h0010);
        check("frame_cnt_5", frame_cnt, 5);
        idle(1);

        // Deselect together with the final byte still commits
        send(8'h02);
        bus.spi_nss = 1'b1;
        send(8'h77);
        check("nss_final_env", env, 8'h77);
        check("nss_final_stb", env_stb, 1);
        check("nss_final_no_err", cmd_err, 0);
        check("frame_cnt_6", frame_cnt, 6);
        bus.spi_nss = 1'b0;

        // Deselect together with a non-final byte aborts and drops it
        send(8'h01);
        bus.spi_nss = 1'b1;
        send(8'hAA);
        check("nss_nonfinal_err", cmd_err, 1);
        check("nss_nonfinal_state", state_dbg, 0);
        bus.spi_nss = 1'b0;
        send(8'h02);
        send(8'h33);
        check("after_nonfinal_env", env, 8'h33);
        check("after_nonfinal_freq", freq, 16'h0010);
        check("frame_cnt_7", frame_cnt, 7);

        // Deselect while idle does nothing
        bus.spi_nss = 1'b1;
        idle(3);
        check("nss_idle_err", cmd_err, 0);
        check("nss_idle_state", state_dbg, 0);
        bus.spi_nss = 1'b0;

        // Partial frame left waiting
        send(8'h03);
        send(8'h11);
        idle(7);
        check("to_wait_state", state_dbg, 2);
        check("to_wait_err", cmd_err, 0);
`ifdef SPI_CMD_TIMEOUT_EN
        idle(1);
        check("timeout_err", cmd_err, 1);
        check("timeout_state", state_dbg, 0);
        check("timeout_freq2", freq2, 16'hBEEF);
        check("timeout_frame_cnt", frame_cnt, 7);
`else
        idle(13);
        check("no_timeout_state", state_dbg, 2);
        check("no_timeout_err", cmd_err, 0);
        send(8'h22);
        check("late_freq2", freq2, 16'h1122);
        check("late_frame_cnt", frame_cnt, 8);
`endif
        idle(1);

        // Asynchronous reset mid-frame
        send(8'h01);
        send(8'hFF);
        nreset = 1'b0;
        #1;
        check("async_rst_freq", freq, 0);
        check("async_rst_freq2", freq2, 0);
        check("async_rst_env", env, 0);
        check("async_rst_env2", env2, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        check("async_rst_ready", bus.rx_ready, 0);
        check("async_rst_state", state_dbg, 0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        check("post_rst_err", cmd_err, 0);
        check("post_rst_state", state_dbg, 0);

        // frame_cnt wrap
        for (int i = 0; i < 255; i++) begin
            send(8'h02);
            send(8'(i));
        end
        check("frame_cnt_255", frame_cnt, 255);
        check("env_254", env, 8'hFE);
        send(8'h02);
        send(8'hFF);
        check("frame_cnt_wrap", frame_cnt, 0);
        check("env_ff", env, 8'hFF);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
